// File: rtl/obstacle_sequencer.sv
// obstacle_sequencer: chooses a pseudo-random wave from the obstacle
// position ROM, latches both obstacle positions and scrolls them down the
// screen once per video frame.
// Optional feature macro: SPEEDUP_EN. When it is defined, the scroll step
// goes up by one every 8 completed waves, up to a maximum of 15.
//
// state | meaning
// IDLE  | game stopped, obstacles hidden, positions held
// PICK  | wait for an LFSR value 0..5 to use as the ROM index
// LOAD  | ROM output valid for rom_index; latch positions and actives
// RUN   | scroll on frame_tick until both obstacles have left the play area
module obstacle_sequencer #(
    parameter logic [3:0] SPEED     = 4'd4,
    parameter logic [9:0] Y_LIMIT   = 10'd600,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       frame_tick,
    input  logic [9:0] rom_x0,
    input  logic [9:0] rom_y0,
    input  logic [9:0] rom_x1,
    input  logic [9:0] rom_y1,
    output logic [2:0] rom_index,
    output logic [9:0] obs0_x,
    output logic [9:0] obs0_y,
    output logic [9:0] obs1_x,
    output logic [9:0] obs1_y,
    output logic       obs0_active,
    output logic       obs1_active,
    output logic       wave_done,
    output logic [7:0] wave_count,
    output logic [3:0] speed
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PICK = 2'd1;
    localparam logic [1:0] ST_LOAD = 2'd2;
    localparam logic [1:0] ST_RUN  = 2'd3;

    logic [1:0]  state;
    logic [7:0]  lfsr;
    logic        lfsr_fb;
    logic [10:0] y0_sum;
    logic [10:0] y1_sum;
    logic [9:0]  y0_next;
    logic [9:0]  y1_next;
    logic [7:0]  wave_count_inc;
    logic [3:0]  speed_next;

    assign lfsr_fb        = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
    assign wave_count_inc = wave_count + 8'd1;

    // The LFSR runs freely in every state, so the wave chosen depends on timing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[6:0], lfsr_fb};
        end
    end

    // The scroll step is added with a carry bit, so a result above 0x3FF clamps instead of wrapping.
    always_comb begin
        y0_sum  = {1'b0, obs0_y} + {7'd0, speed};
        y1_sum  = {1'b0, obs1_y} + {7'd0, speed};
        y0_next = y0_sum[10] ? 10'h3FF : y0_sum[9:0];
        y1_next = y1_sum[10] ? 10'h3FF : y1_sum[9:0];
    end

`ifdef SPEEDUP_EN
    // The speed rises by one when the completed-wave count reaches a multiple of 8.
    always_comb begin
        speed_next = speed;
        if (wave_count_inc[2:0] == 3'd0 && speed != 4'hF) begin
            speed_next = speed + 4'd1;
        end
    end
`else
    assign speed_next = speed;
`endif

    // Main sequencer. Dropping run overrides every state and hides the obstacles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            rom_index   <= 3'd0;
            obs0_x      <= 10'd0;
            obs0_y      <= 10'd0;
            obs1_x      <= 10'd0;
            obs1_y      <= 10'd0;
            obs0_active <= 1'b0;
            obs1_active <= 1'b0;
            wave_done   <= 1'b0;
            wave_count  <= 8'd0;
            speed       <= SPEED;
        end else begin
            wave_done <= 1'b0;
            if (!run) begin
                state       <= ST_IDLE;
                obs0_active <= 1'b0;
                obs1_active <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: state <= ST_PICK;
                    ST_PICK: begin
                        if (lfsr[2:0] < 3'd6) begin
                            rom_index <= lfsr[2:0];
                            state     <= ST_LOAD;
                        end
                    end
                    ST_LOAD: begin
                        obs0_x      <= rom_x0;
                        obs0_y      <= rom_y0;
                        obs1_x      <= rom_x1;
                        obs1_y      <= rom_y1;
                        obs0_active <= (rom_y0 < Y_LIMIT);
                        obs1_active <= (rom_y1 < Y_LIMIT);
                        state       <= ST_RUN;
                    end
                    ST_RUN: begin
                        // The end of a wave takes priority over scrolling; a frame_tick in this cycle is dropped.
                        if (!obs0_active && !obs1_active) begin
                            wave_done  <= 1'b1;
                            wave_count <= wave_count_inc;
                            speed      <= speed_next;
                            state      <= ST_PICK;
                        end else if (frame_tick) begin
                            if (obs0_active) begin
                                obs0_y      <= y0_next;
                                obs0_active <= (y0_next < Y_LIMIT);
                            end
                            if (obs1_active) begin
                                obs1_y      <= y1_next;
                                obs1_active <= (y1_next < Y_LIMIT);
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_obstacle_sequencer.sv
// Testbench for obstacle_sequencer. A table-driven ROM model feeds two
// instances: one with default parameters, and one with Y_LIMIT=0x3FF so the
// saturating add can be reached. Expected positions are computed in closed
// form from the scroll rules.
module tb_obstacle_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;
    logic run = 1'b0;
    logic frame_tick = 1'b0;

    logic [9:0] tbl_x0 [8];
    logic [9:0] tbl_y0 [8];
    logic [9:0] tbl_x1 [8];
    logic [9:0] tbl_y1 [8];

    logic [9:0] rom_x0, rom_y0, rom_x1, rom_y1;
    logic [2:0] rom_index;
    logic [9:0] obs0_x, obs0_y, obs1_x, obs1_y;
    logic       obs0_active, obs1_active, wave_done;
    logic [7:0] wave_count;
    logic [3:0] speed;

    logic [9:0] s_rom_x0, s_rom_y0, s_rom_x1, s_rom_y1;
    logic [2:0] s_rom_index;
    logic [9:0] s_obs0_x, s_obs0_y, s_obs1_x, s_obs1_y;
    logic       s_obs0_active, s_obs1_active, s_wave_done;
    logic [7:0] s_wave_count;
    logic [3:0] s_speed;

    assign rom_x0   = tbl_x0[rom_index];
    assign rom_y0   = tbl_y0[rom_index];
    assign rom_x1   = tbl_x1[rom_index];
    assign rom_y1   = tbl_y1[rom_index];
    assign s_rom_x0 = tbl_x0[s_rom_index];
    assign s_rom_y0 = tbl_y0[s_rom_index];
    assign s_rom_x1 = tbl_x1[s_rom_index];
    assign s_rom_y1 = tbl_y1[s_rom_index];

    obstacle_sequencer dut (
        .clk(clk), .rst_n(rst_n), .run(run), .frame_tick(frame_tick),
        .rom_x0(rom_x0), .rom_y0(rom_y0), .rom_x1(rom_x1), .rom_y1(rom_y1),
        .rom_index(rom_index), .obs0_x(obs0_x), .obs0_y(obs0_y),
        .obs1_x(obs1_x), .obs1_y(obs1_y), .obs0_active(obs0_active),
        .obs1_active(obs1_active), .wave_done(wave_done),
        .wave_count(wave_count), .speed(speed)
    );

    obstacle_sequencer #(.Y_LIMIT(10'h3FF)) dut_sat (
        .clk(clk), .rst_n(rst_n), .run(run), .frame_tick(frame_tick),
        .rom_x0(s_rom_x0), .rom_y0(s_rom_y0), .rom_x1(s_rom_x1), .rom_y1(s_rom_y1),
        .rom_index(s_rom_index), .obs0_x(s_obs0_x), .obs0_y(s_obs0_y),
        .obs1_x(s_obs1_x), .obs1_y(s_obs1_y), .obs0_active(s_obs0_active),
        .obs1_active(s_obs1_active), .wave_done(s_wave_done),
        .wave_count(s_wave_count), .speed(s_speed)
    );

    int n_checks = 0;
    int n_fail = 0;
    int n_wd = 0;

    // Reference LFSR: 8-bit Fibonacci with taps 8,6,5,4, shifting toward the MSB.
    logic [7:0] m_lfsr;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= 8'hA5;
        else        m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    always @(negedge clk) begin
        if (wave_done === 1'b1) n_wd++;
    end

    function automatic int ticks_to_leave(input int y0, input int spd, input int lim);
        return (lim - y0 + spd - 1) / spd;
    endfunction

    function automatic logic [9:0] exp_y(input int y0, input int n, input int spd, input int lim);
        int k;
        int v;
        if (y0 >= lim) return 10'(y0);
        k = ticks_to_leave(y0, spd, lim);
        v = y0 + ((n < k) ? n : k) * spd;
        if (v > 1023) v = 1023;
        return 10'(v);
    endfunction

    function automatic logic exp_act(input int y0, input int n, input int spd, input int lim);
        return (y0 < lim) && (n < ticks_to_leave(y0, spd, lim));
    endfunction

    task automatic fill_table(input int y0, input int y1);
        for (int i = 0; i < 8; i++) begin
            tbl_x0[i] = 10'($urandom_range(0, 1023));
            tbl_x1[i] = 10'($urandom_range(0, 1023));
            tbl_y0[i] = 10'(y0);
            tbl_y1[i] = 10'(y1);
        end
    endtask

    task automatic do_reset;
        run = 1'b0;
        frame_tick = 1'b0;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic tick(input int gap);
        frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    // Starts from IDLE: raises run, follows the reference LFSR to the accepted index, then checks the load.
    task automatic load_wave(output logic [2:0] idx);
        logic [2:0] v;
        bit found;
        found = 1'b0;
        v = 3'd0;
        run = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 64 && !found; i++) begin
            v = m_lfsr[2:0];
            @(posedge clk); #1;
            if (v < 3'd6) found = 1'b1;
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL pick_timeout: reference lfsr produced no usable index within 64 clks");
        end
        n_checks++;
        if (rom_index !== v) begin
            n_fail++;
            $display("FAIL pick_index: rom_index=%0d expected %0d", rom_index, v);
        end
        @(posedge clk); #1;
        n_checks++;
        if ({obs0_x, obs0_y, obs1_x, obs1_y} !== {tbl_x0[v], tbl_y0[v], tbl_x1[v], tbl_y1[v]}) begin
            n_fail++;
            $display("FAIL load_pos: got (%h,%h)(%h,%h) expected (%h,%h)(%h,%h)", obs0_x, obs0_y,
                     obs1_x, obs1_y, tbl_x0[v], tbl_y0[v], tbl_x1[v], tbl_y1[v]);
        end
        n_checks++;
        if ({obs0_active, obs1_active} !== {tbl_y0[v] < 10'd600, tbl_y1[v] < 10'd600}) begin
            n_fail++;
            $display("FAIL load_active: got %b%b for y0=%0d y1=%0d", obs0_active, obs1_active,
                     tbl_y0[v], tbl_y1[v]);
        end
        idx = v;
    endtask

    task automatic test_reset;
        fill_table(0, 0);
        run = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({rom_index, obs0_x, obs0_y, obs1_x, obs1_y, obs0_active, obs1_active, wave_done, wave_count, speed}
            !== {3'd0, 40'd0, 3'b000, 8'd0, 4'd4}) begin
            n_fail++;
            $display("FAIL reset_values: idx=%0d y0=%0d y1=%0d act=%b%b wd=%b wc=%0d spd=%0d",
                     rom_index, obs0_y, obs1_y, obs0_active, obs1_active, wave_done, wave_count, speed);
        end
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        n_checks++;
        if ({rom_index, obs0_x, obs0_y, obs1_x, obs1_y, obs0_active, obs1_active, wave_done, wave_count, speed}
            !== {3'd0, 40'd0, 3'b000, 8'd0, 4'd4}) begin
            n_fail++;
            $display("FAIL idle_values: idx=%0d act=%b%b wd=%b wc=%0d spd=%0d",
                     rom_index, obs0_active, obs1_active, wave_done, wave_count, speed);
        end
    endtask

    task automatic test_example_entry;
        logic [2:0] idx;
        do_reset;
        fill_table(0, 0);
        for (int i = 0; i < 8; i++) begin
            tbl_x0[i] = 10'h117; tbl_y0[i] = 10'h000;
            tbl_x1[i] = 10'h169; tbl_y1[i] = 10'h262;
        end
        load_wave(idx);
        n_checks++;
        if ({obs0_active, obs1_active} !== 2'b10) begin
            n_fail++;
            $display("FAIL example_active: got %b%b expected 10", obs0_active, obs1_active);
        end
    endtask

    task automatic test_full_wave;
        logic [2:0] idx;
        int base;
        do_reset;
        fill_table(0, 0);
        load_wave(idx);
        base = n_wd;
        for (int n = 1; n <= 150; n++) begin
            tick((n == 150) ? 0 : $urandom_range(0, 2));
            if (n == 75) begin
                n_checks++;
                if ({obs0_y, obs1_y, obs0_active, obs1_active} !== {10'd300, 10'd300, 2'b11}) begin
                    n_fail++;
                    $display("FAIL mid_wave: y=%0d,%0d act=%b%b expected 300,300 11",
                             obs0_y, obs1_y, obs0_active, obs1_active);
                end
            end
        end
        n_checks++;
        if ({obs0_y, obs1_y, obs0_active, obs1_active, wave_done} !== {10'd600, 10'd600, 3'b000}) begin
            n_fail++;
            $display("FAIL wave_end: y=%0d,%0d act=%b%b wd=%b expected 600,600 00 0",
                     obs0_y, obs1_y, obs0_active, obs1_active, wave_done);
        end
        frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
        n_checks++;
        if ({wave_done, wave_count} !== {1'b1, 8'd1}) begin
            n_fail++;
            $display("FAIL wave_done: wd=%b wc=%0d expected 1,1", wave_done, wave_count);
        end
        @(posedge clk); #1;
        n_checks++;
        if (wave_done !== 1'b0 || (n_wd - base) != 1) begin
            n_fail++;
            $display("FAIL wave_done_pulse: wd=%b pulses=%0d expected 0,1", wave_done, n_wd - base);
        end
        run = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_random_waves;
        logic [2:0] idx;
        int y0, y1, x0, x1, k0, n, base;
        for (int it = 0; it < 5; it++) begin
            do_reset;
            for (int i = 0; i < 8; i++) begin
                tbl_x0[i] = 10'($urandom_range(0, 1023));
                tbl_x1[i] = 10'($urandom_range(0, 1023));
                tbl_y0[i] = 10'($urandom_range(0, 599));
                tbl_y1[i] = ($urandom_range(0, 3) == 0) ? 10'h262 : 10'($urandom_range(0, 599));
            end
            load_wave(idx);
            y0 = int'(tbl_y0[idx]); y1 = int'(tbl_y1[idx]);
            x0 = int'(tbl_x0[idx]); x1 = int'(tbl_x1[idx]);
            k0 = ticks_to_leave(y0, 4, 600);
            n = $urandom_range(0, (k0 - 1 < 40) ? k0 - 1 : 40);
            base = n_wd;
            repeat (n) tick($urandom_range(0, 2));
            n_checks++;
            if ({obs0_y, obs1_y} !== {exp_y(y0, n, 4, 600), exp_y(y1, n, 4, 600)}) begin
                n_fail++;
                $display("FAIL rand_y: it=%0d n=%0d got %0d,%0d expected %0d,%0d", it, n, obs0_y, obs1_y,
                         exp_y(y0, n, 4, 600), exp_y(y1, n, 4, 600));
            end
            n_checks++;
            if ({obs0_active, obs1_active, obs0_x, obs1_x, n_wd == base}
                !== {exp_act(y0, n, 4, 600), exp_act(y1, n, 4, 600), 10'(x0), 10'(x1), 1'b1}) begin
                n_fail++;
                $display("FAIL rand_state: it=%0d act=%b%b x=%h,%h pulses=%0d", it, obs0_active,
                         obs1_active, obs0_x, obs1_x, n_wd - base);
            end
        end
    endtask

    task automatic test_saturation;
        logic [2:0] idx;
        do_reset;
        fill_table(10'h3FE, 10'h3FF);
        load_wave(idx);
        n_checks++;
        if ({s_obs0_y, s_obs0_active, s_obs1_active} !== {10'h3FE, 2'b10}) begin
            n_fail++;
            $display("FAIL sat_load: y=%h act=%b%b expected 3fe 10", s_obs0_y, s_obs0_active, s_obs1_active);
        end
        tick(0);
        n_checks++;
        if ({s_obs0_y, s_obs0_active, s_obs1_y} !== {10'h3FF, 1'b0, 10'h3FF}) begin
            n_fail++;
            $display("FAIL sat_tick: y0=%h act=%b y1=%h expected 3ff 0 3ff", s_obs0_y, s_obs0_active, s_obs1_y);
        end
        n_checks++;
        if ({obs0_y, obs0_active} !== {10'h3FE, 1'b0}) begin
            n_fail++;
            $display("FAIL inactive_hold: y0=%h act=%b expected 3fe 0", obs0_y, obs0_active);
        end
        run = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_run_drop;
        logic [2:0] idx;
        int base;
        do_reset;
        fill_table(0, 0);
        load_wave(idx);
        repeat (50) tick(0);
        base = n_wd;
        run = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if ({obs0_y, obs1_y, obs0_active, obs1_active, wave_done} !== {10'd200, 10'd200, 3'b000}) begin
            n_fail++;
            $display("FAIL run_drop: y=%0d,%0d act=%b%b wd=%b expected 200,200 00 0",
                     obs0_y, obs1_y, obs0_active, obs1_active, wave_done);
        end
        tick(5);
        n_checks++;
        if ({obs0_y, obs1_y, wave_count} !== {10'd200, 10'd200, 8'd0} || n_wd != base) begin
            n_fail++;
            $display("FAIL idle_hold: y=%0d,%0d wc=%0d pulses=%0d expected 200,200 0 0",
                     obs0_y, obs1_y, wave_count, n_wd - base);
        end
        fill_table(100, 10'h262);
        load_wave(idx);
    endtask

    task automatic test_reset_midwave;
        logic [2:0] idx;
        do_reset;
        fill_table(0, 0);
        load_wave(idx);
        repeat (10) tick(1);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({rom_index, obs0_x, obs0_y, obs1_x, obs1_y, obs0_active, obs1_active, wave_done, wave_count, speed}
            !== {3'd0, 40'd0, 3'b000, 8'd0, 4'd4}) begin
            n_fail++;
            $display("FAIL async_reset: idx=%0d y=%0d,%0d act=%b%b", rom_index, obs0_y, obs1_y,
                     obs0_active, obs1_active);
        end
        run = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_speedup;
        int cnt;
        logic [3:0] exp_spd;
`ifdef SPEEDUP_EN
        exp_spd = 4'd5;
`else
        exp_spd = 4'd4;
`endif
        do_reset;
        fill_table(10'h262, 10'h262);
        run = 1'b1;
        cnt = 0;
        for (int c = 0; c < 3000 && cnt < 8; c++) begin
            @(posedge clk); #1;
            if (wave_done === 1'b1) begin
                cnt++;
                n_checks++;
                if (wave_count !== 8'(cnt)) begin
                    n_fail++;
                    $display("FAIL wave_count: got %0d expected %0d", wave_count, cnt);
                end
                if (cnt == 7) begin
                    n_checks++;
                    if (speed !== 4'd4) begin
                        n_fail++;
                        $display("FAIL speed_wave7: got %0d expected 4", speed);
                    end
                end
            end
        end
        n_checks++;
        if (cnt != 8 || speed !== exp_spd) begin
            n_fail++;
            $display("FAIL speed_wave8: waves=%0d speed=%0d expected 8 waves speed %0d", cnt, speed, exp_spd);
        end
        run = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset;
        test_example_entry;
        test_full_wave;
        test_random_waves;
        test_saturation;
        test_run_drop;
        test_reset_midwave;
        test_speedup;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/obstacle_sequencer.md
Name: obstacle_sequencer

Overview:
Drives the 3-bit index into the obstacle position ROM and latches the two obstacle positions the ROM returns. It then scrolls both obstacles down the screen once per video frame. When a wave of obstacles has left the play area, it picks a new pseudo-random index and loads the next wave. The block sits between the VGA frame timing and the sprite/collision logic of the race game.

Parameters:
SPEED, 4, pixels added to each obstacle y per frame_tick (1..15)
Y_LIMIT, 10'd600, an obstacle with y >= Y_LIMIT is inactive; ROM value 10'h262 (610) therefore means "no obstacle"
LFSR_SEED, 8'hA5, LFSR reset value; must be non-zero

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
run  in  1  game running; low forces IDLE
frame_tick  in  1  one-cycle pulse per video frame
rom_x0  in  10  ROM output, obstacle 0 x
rom_y0  in  10  ROM output, obstacle 0 y
rom_x1  in  10  ROM output, obstacle 1 x
rom_y1  in  10  ROM output, obstacle 1 y
rom_index  out  3  registered index to position ROM
obs0_x  out  10  obstacle 0 x
obs0_y  out  10  obstacle 0 y
obs1_x  out  10  obstacle 1 x
obs1_y  out  10  obstacle 1 y
obs0_active  out  1  obstacle 0 on screen
obs1_active  out  1  obstacle 1 on screen
wave_done  out  1  one-cycle pulse when a wave finishes
wave_count  out  8  completed waves, wraps 255->0
speed  out  4  current scroll step

Behaviour:
- Reset (async, rst_n=0): state=IDLE, lfsr=LFSR_SEED, rom_index=0, all obs_x/obs_y=0, actives=0, wave_done=0, wave_count=0, speed=SPEED.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4. Steps every clk while rst_n=1, in every state.
- FSM states: IDLE, PICK, LOAD, RUN.
  - IDLE: if run=1 -> PICK.
  - PICK: if lfsr[2:0] < 6, then rom_index <= lfsr[2:0] and -> LOAD; otherwise stay (values 6, 7 rejected).
  - LOAD: ROM is combinational on the registered rom_index. Latch obs*_x/obs*_y from rom_*. Set obsN_active = (rom_yN < Y_LIMIT). -> RUN. Total latency from entering PICK with a valid LFSR value to valid positions: 2 clks.
  - RUN, on frame_tick: for each active obstacle, y <= y + speed, computed in 11 bits and saturated to 10'h3FF. If the new y >= Y_LIMIT, clear that active flag in the same cycle. x is never modified.
  - RUN, when both actives=0 (checked every clk, also right after LOAD if the ROM gave no active obstacle): wave_done=1 for one clk, wave_count++, -> PICK.
- frame_tick outside RUN is ignored. frame_tick in the LOAD cycle is ignored; no scroll happens in the load frame.
- run=0 in any state: next clk state=IDLE, actives=0, positions hold, wave_done=0. wave_count and speed hold.
- wave_done and frame_tick in the same cycle: the wave finishes first; the tick is dropped.
- Reset mid-wave: all outputs return to reset values immediately (async).

Optional Feature:
SPEEDUP_EN.
- Defined: on every wave_done where the new wave_count[2:0]==0, speed increments by 1, saturating at 15.
- Undefined: speed is constant at SPEED.

Test Plan:
1. Reset with run=0, 20 clks -> all outputs at reset values, state IDLE, rom_index=0.
2. run=1 -> within 2 clks of the first lfsr[2:0]<6, rom_index equals that value and the latched positions equal the ROM entry. Example for index 5: obs0=(0x117,0), obs1=(0x169,0x262), obs0_active=1, obs1_active=0.
3. Wave with both y=0, SPEED=4 -> after 150 frame_ticks both y=600, actives=0, and one wave_done pulse with wave_count=1.
4. Bench ROM returns y=0x3FE with one tick pending -> y saturates at 0x3FF (no wrap), active=0.
5. Deassert run mid-RUN at y=200 -> next clk state IDLE, actives=0, wave_done never pulses. Reassert run -> fresh PICK.
6. SPEEDUP_EN defined, 8 forced short waves (ROM y=0x262 for both obstacles) -> speed=5 after the 8th wave_done. Without the macro, speed stays 4.
